// File: rtl/levinson_div_pipe.sv
`default_nettype none
// ============================================================================
// levinson_div_pipe : fixed-latency signed divider with saturation, tagging
//                     and clock-enable stall for the Levinson-Durbin recursion
// Rev 1.0
// ============================================================================
module levinson_div_pipe #(
  parameter int NUM_W   = 64,
  parameter int DEN_W   = 33,
  parameter int QUO_W   = 32,
  parameter int LATENCY = 8,
  parameter int TAG_W   = 4,
  parameter int SAT     = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clken,
  input  logic             in_valid,
  input  logic [NUM_W-1:0] numer,
  input  logic [DEN_W-1:0] denom,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [QUO_W-1:0] quotient,
  output logic [DEN_W-1:0] remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_zero,
  output logic             overflow
);

  // One guard bit so that -2^(NUM_W-1) / -1 is representable before range checking.
  localparam int XW = NUM_W + 1;

  localparam logic signed [XW-1:0] c_q_max = {{(XW-QUO_W+1){1'b0}}, {(QUO_W-1){1'b1}}};
  localparam logic signed [XW-1:0] c_q_min = {{(XW-QUO_W+1){1'b1}}, {(QUO_W-1){1'b0}}};
  localparam logic [QUO_W-1:0]     c_sat_pos = {1'b0, {(QUO_W-1){1'b1}}};
  localparam logic [QUO_W-1:0]     c_sat_neg = {1'b1, {(QUO_W-1){1'b0}}};

  logic signed [XW-1:0] w_num_x;
  logic signed [XW-1:0] w_den_x;
  logic signed [XW-1:0] w_den_safe;
  logic signed [XW-1:0] w_quo_x;
  logic                 w_den_zero;
  logic                 w_ovf_raw;
  logic [QUO_W-1:0]     w_quo;
  logic [DEN_W-1:0]     w_rem;
  logic                 w_dz;
  logic                 w_ovf;

  assign w_num_x    = {numer[NUM_W-1], numer};
  assign w_den_x    = {{(XW-DEN_W){denom[DEN_W-1]}}, denom};
  assign w_den_zero = (denom == '0);
  assign w_den_safe = w_den_zero ? XW'(1) : w_den_x;
  assign w_quo_x    = w_num_x / w_den_safe;
  assign w_ovf_raw  = (w_quo_x > c_q_max) || (w_quo_x < c_q_min);

  always_comb begin
    w_quo = w_quo_x[QUO_W-1:0];
    w_rem = DEN_W'(w_num_x % w_den_safe);
    w_dz  = 1'b0;
    w_ovf = 1'b0;
    if (w_den_zero) begin
      w_dz  = 1'b1;
      w_rem = '0;
      w_quo = numer[NUM_W-1] ? c_sat_neg : c_sat_pos;
    end else if (w_ovf_raw) begin
      w_ovf = 1'b1;
      if (SAT != 0) begin
        w_quo = w_quo_x[XW-1] ? c_sat_neg : c_sat_pos;
      end
    end
  end

  logic             r_valid [LATENCY];
  logic [QUO_W-1:0] r_quo   [LATENCY];
  logic [DEN_W-1:0] r_rem   [LATENCY];
  logic [TAG_W-1:0] r_tag   [LATENCY];
  logic             r_dz    [LATENCY];
  logic             r_ovf   [LATENCY];

  // Flags are qualified by valid at entry so bubbles never carry a flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_valid[i] <= 1'b0;
        r_quo[i]   <= '0;
        r_rem[i]   <= '0;
        r_tag[i]   <= '0;
        r_dz[i]    <= 1'b0;
        r_ovf[i]   <= 1'b0;
      end
    end else if (clken) begin
      r_valid[0] <= in_valid;
      r_quo[0]   <= w_quo;
      r_rem[0]   <= w_rem;
      r_tag[0]   <= in_tag;
      r_dz[0]    <= w_dz & in_valid;
      r_ovf[0]   <= w_ovf & in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_quo[i]   <= r_quo[i-1];
        r_rem[i]   <= r_rem[i-1];
        r_tag[i]   <= r_tag[i-1];
        r_dz[i]    <= r_dz[i-1];
        r_ovf[i]   <= r_ovf[i-1];
      end
    end
  end

  assign out_valid = r_valid[LATENCY-1];
  assign quotient  = r_quo[LATENCY-1];
  assign remainder = r_rem[LATENCY-1];
  assign out_tag   = r_tag[LATENCY-1];
  assign div_zero  = r_dz[LATENCY-1];
  assign overflow  = r_ovf[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_levinson_div_pipe.sv
`default_nettype none
// ============================================================================
// tb_levinson_div_pipe : directed table, stall, reset and random checks of
//                        levinson_div_pipe against a magnitude/sign model
// Rev 1.0
// ============================================================================
module tb_levinson_div_pipe;

  localparam int LATENCY = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] numer = '0;
  logic [32:0] denom = '0;
  logic [3:0]  in_tag = '0;

  logic        out_valid, div_zero, overflow;
  logic [31:0] quotient;
  logic [32:0] remainder;
  logic [3:0]  out_tag;

  logic        wv, wdz, wov;
  logic [31:0] wq;
  logic [32:0] wr;
  logic [3:0]  wt;

  always #5 clock = ~clock;

  levinson_div_pipe #(.NUM_W(64), .DEN_W(33), .QUO_W(32), .LATENCY(LATENCY), .TAG_W(4), .SAT(1)) dut (
    .clock(clock), .reset_n(reset_n), .clken(clken), .in_valid(in_valid),
    .numer(numer), .denom(denom), .in_tag(in_tag),
    .out_valid(out_valid), .quotient(quotient), .remainder(remainder),
    .out_tag(out_tag), .div_zero(div_zero), .overflow(overflow)
  );

  levinson_div_pipe #(.NUM_W(64), .DEN_W(33), .QUO_W(32), .LATENCY(LATENCY), .TAG_W(4), .SAT(0)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .clken(clken), .in_valid(in_valid),
    .numer(numer), .denom(denom), .in_tag(in_tag),
    .out_valid(wv), .quotient(wq), .remainder(wr),
    .out_tag(wt), .div_zero(wdz), .overflow(wov)
  );

  typedef struct {
    logic [63:0] n;
    logic [32:0] d;
    logic [3:0]  tag;
    logic [31:0] q;
    logic [31:0] qw;
    logic [32:0] r;
    logic        dz;
    logic        ov;
    int          k;
  } exp_t;

  exp_t         sb[$];
  exp_t         cur;
  exp_t         vec[13];
  int           en_cnt = 0;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           pulses = 0;
  logic [127:0] prev = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: divide magnitudes, then apply sign rules and range limits.
  function automatic exp_t model(input logic [63:0] n, input logic [32:0] d, input logic [3:0] t);
    exp_t e;
    logic [63:0] nm, dm, qm, rm, dext;
    logic neg;
    e.n = n; e.d = d; e.tag = t; e.k = 0;
    dext = {{31{d[32]}}, d};
    nm = n[63] ? -n : n;
    dm = dext[63] ? -dext : dext;
    if (dm == 64'd0) begin
      e.dz = 1'b1; e.ov = 1'b0; e.r = '0;
      e.q  = n[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.qw = e.q;
    end else begin
      qm = nm / dm;
      rm = nm % dm;
      neg = n[63] ^ d[32];
      e.dz = 1'b0;
      e.ov = neg ? (qm > 64'h8000_0000) : (qm > 64'h7FFF_FFFF);
      e.qw = neg ? 32'(-qm) : qm[31:0];
      e.q  = !e.ov ? e.qw : (neg ? 32'h8000_0000 : 32'h7FFF_FFFF);
      e.r  = n[63] ? 33'(-rm) : rm[32:0];
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [63:0] n, input logic [32:0] d, input logic [3:0] t,
                              input logic [31:0] q, input logic [31:0] qw, input logic [32:0] r,
                              input logic dz, input logic ov);
    exp_t e;
    e.n = n; e.d = d; e.tag = t; e.q = q; e.qw = qw; e.r = r; e.dz = dz; e.ov = ov; e.k = 0;
    return e;
  endfunction

  function automatic logic [63:0] rnd_num();
    logic [63:0] x;
    x = {$urandom, $urandom};
    if ($urandom_range(0, 19) == 0) x = 64'h8000_0000_0000_0000;
    else x = 64'($signed(x) >>> $urandom_range(0, 63));
    return x;
  endfunction

  function automatic logic [32:0] rnd_den();
    logic [63:0] x;
    logic [32:0] d;
    x = {$urandom, $urandom};
    d = x[32:0];
    case ($urandom_range(0, 9))
      0:       d = '0;
      1:       d = '1;
      2:       d = 33'd1;
      default: d = 33'($signed(d) >>> $urandom_range(0, 32));
    endcase
    return d;
  endfunction

  task automatic apply(input exp_t e, input logic v);
    numer = e.n; denom = e.d; in_tag = e.tag; in_valid = v; cur = e;
  endtask

  task automatic check(input bit en);
    logic [127:0] now;
    bit expv;
    exp_t e;
    now = {23'd0, out_valid, quotient, remainder, out_tag, div_zero, overflow, wv, wq};
    if (!en) begin
      chk("frozen", now, prev);
    end else begin
      expv = (sb.size() > 0) && (sb[0].k <= en_cnt - LATENCY + 1);
      chk("out_valid", 128'(out_valid), 128'(expv));
      chk("wrap_out_valid", 128'(wv), 128'(expv));
      if (expv) begin
        e = sb.pop_front();
        chk("quotient", 128'(quotient), 128'(e.q));
        chk("remainder", 128'(remainder), 128'(e.r));
        chk("out_tag", 128'(out_tag), 128'(e.tag));
        chk("div_zero", 128'(div_zero), 128'(e.dz));
        chk("overflow", 128'(overflow), 128'(e.ov));
        chk("wrap_quotient", 128'(wq), 128'(e.qw));
      end else begin
        chk("idle_flags", 128'({div_zero, overflow, wdz, wov}), 128'(0));
      end
      if (out_valid) pulses++;
    end
    prev = now;
  endtask

  task automatic cycle();
    bit en;
    en = clken;
    @(posedge clock);
    if (en) begin
      en_cnt++;
      if (in_valid) begin
        cur.k = en_cnt;
        sb.push_back(cur);
      end
    end
    #1;
    check(en);
  endtask

  initial begin
    int sent;
    bit v;
    vec[0]  = mk(64'd100, 33'd7, 4'd3, 32'd14, 32'd14, 33'd2, 1'b0, 1'b0);
    vec[1]  = mk(-64'sd100, 33'd7, 4'd1, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 33'h1_FFFF_FFFE, 1'b0, 1'b0);
    vec[2]  = mk(64'd100, -33'sd7, 4'd2, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 33'd2, 1'b0, 1'b0);
    vec[3]  = mk(64'd5, 33'd0, 4'd4, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 33'd0, 1'b1, 1'b0);
    vec[4]  = mk(-64'sd5, 33'd0, 4'd5, 32'h8000_0000, 32'h8000_0000, 33'd0, 1'b1, 1'b0);
    vec[5]  = mk(64'd1 << 40, 33'd1, 4'd6, 32'h7FFF_FFFF, 32'h0000_0000, 33'd0, 1'b0, 1'b1);
    vec[6]  = mk(-(64'd1 << 40), 33'd3, 4'd7, 32'h8000_0000, 32'hAAAA_AAAB, 33'h1_FFFF_FFFF, 1'b0, 1'b1);
    vec[7]  = mk(64'h8000_0000_0000_0000, '1, 4'd8, 32'h7FFF_FFFF, 32'h0000_0000, 33'd0, 1'b0, 1'b1);
    vec[8]  = mk(64'h7FFF_FFFF, 33'd1, 4'd9, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 33'd0, 1'b0, 1'b0);
    vec[9]  = mk(-(64'd1 << 31), 33'd1, 4'd10, 32'h8000_0000, 32'h8000_0000, 33'd0, 1'b0, 1'b0);
    vec[10] = mk(64'd1 << 31, 33'd1, 4'd11, 32'h7FFF_FFFF, 32'h8000_0000, 33'd0, 1'b0, 1'b1);
    vec[11] = mk(64'd0, -33'sd5, 4'd12, 32'd0, 32'd0, 33'd0, 1'b0, 1'b0);
    vec[12] = mk(-64'sd7, 33'd7, 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'd0, 1'b0, 1'b0);

    // Reset state while inputs are active.
    clken = 1'b1;
    apply(vec[0], 1'b1);
    repeat (2) @(posedge clock);
    #1;
    chk("reset_valid", 128'({out_valid, wv}), 128'(0));
    chk("reset_data", 128'({quotient, remainder, out_tag}), 128'(0));
    chk("reset_flags", 128'({div_zero, overflow}), 128'(0));
    in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // Directed table, back to back.
    for (int i = 0; i < 13; i++) begin
      apply(vec[i], 1'b1);
      cycle();
    end
    in_valid = 1'b0;
    repeat (LATENCY + 2) cycle();

    // Stall in the middle of a 10-pair stream; pair 5 is held during the stall.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      apply(model(rnd_num(), rnd_den(), 4'(i)), 1'b1);
      if (i == 5) begin
        clken = 1'b0;
        repeat (3) cycle();
        clken = 1'b1;
      end
      cycle();
    end
    in_valid = 1'b0;
    repeat (LATENCY + 2) cycle();
    chk("stall_pulses", 128'(pulses), 128'(10));

    // Reset with results in flight and one already at the output.
    for (int i = 0; i < 9; i++) begin
      apply(model(rnd_num(), rnd_den(), 4'(i)), 1'b1);
      cycle();
    end
    in_valid = 1'b0;
    chk("pre_reset_valid", 128'(out_valid), 128'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_valid", 128'({out_valid, wv}), 128'(0));
    chk("async_reset_flags", 128'({div_zero, overflow}), 128'(0));
    chk("async_reset_quotient", 128'(quotient), 128'(0));
    sb.delete();
    prev = '0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    repeat (LATENCY + 4) cycle();
    chk("no_stale_results", 128'(pulses), 128'(0));
    apply(vec[0], 1'b1);
    cycle();
    in_valid = 1'b0;
    repeat (LATENCY + 2) cycle();
    chk("post_reset_pulses", 128'(pulses), 128'(1));

    // Random traffic with random clock-enable gaps.
    pulses = 0;
    sent = 0;
    for (int i = 0; i < 400; i++) begin
      clken = ($urandom_range(0, 4) != 0);
      v = ($urandom_range(0, 9) < 7);
      apply(model(rnd_num(), rnd_den(), 4'($urandom)), v);
      if (clken && v) sent++;
      cycle();
    end
    clken = 1'b1;
    in_valid = 1'b0;
    repeat (LATENCY + 2) cycle();
    chk("random_pulses", 128'(pulses), 128'(sent));
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
